// File: rtl/countdown_timer_if.sv
// Keypad-to-timer bus: encoded keypress, control levels, 1 Hz tick and the BCD time/status back.
// master drives the controls (keypad/controller side); slave is the timer.
interface countdown_timer_if;
    logic [3:0] Digit;
    logic       loadn;
    logic       start;
    logic       pause;
    logic       clear;
    logic       tick;

    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       running;
    logic       zero;
    logic       done;

    modport master (
        output Digit, loadn, start, pause, clear, tick,
        input  min_tens, min_ones, sec_tens, sec_ones, running, zero, done
    );

    modport slave (
        input  Digit, loadn, start, pause, clear, tick,
        output min_tens, min_ones, sec_tens, sec_ones, running, zero, done
    );
endinterface

// File: rtl/countdown_timer.sv
// MM:SS BCD entry register and 1 Hz countdown; keypress/tick/control take effect at the sampling edge, visible next cycle.
// No backpressure: every input is a level or single-cycle strobe consumed in the cycle it is sampled.
module countdown_timer #(
    parameter int unsigned SEC_TENS_WRAP = 5
) (
    input  logic               clock,
    input  logic               reset,
    countdown_timer_if.slave   tbus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0] min_tens;
        logic [3:0] min_ones;
        logic [3:0] sec_tens;
        logic [3:0] sec_ones;
    } bcd_time_t;

    localparam logic [3:0] WRAP_DIGIT = 4'(SEC_TENS_WRAP);

    state_t    state_q, state_d;
    bcd_time_t time_q,  time_d;
    logic      zero_q,  zero_d;
    logic      done_q,  done_d;
    logic      loadn_q, loadn_d;

    bcd_time_t dec_time;
    logic      press;
    logic      digit_ok;

    assign press    = !tbus.loadn && loadn_q;
    assign digit_ok = (tbus.Digit <= 4'd9);

    // Borrow chain runs digit-wise, so seconds entered above 59 simply count down as typed.
    always_comb begin
        dec_time = time_q;
        if (time_q.sec_ones != 4'd0) begin
            dec_time.sec_ones = time_q.sec_ones - 4'd1;
        end else if (time_q.sec_tens != 4'd0) begin
            dec_time.sec_ones = 4'd9;
            dec_time.sec_tens = time_q.sec_tens - 4'd1;
        end else begin
            if (time_q.min_ones != 4'd0) begin
                dec_time.min_ones = time_q.min_ones - 4'd1;
            end else begin
                dec_time.min_ones = 4'd9;
                dec_time.min_tens = time_q.min_tens - 4'd1;
            end
            dec_time.sec_tens = WRAP_DIGIT;
            dec_time.sec_ones = 4'd9;
        end
    end

    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        done_d  = 1'b0;
        loadn_d = tbus.loadn;

        if (tbus.clear) begin
            time_d  = '0;
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (tbus.start) begin
                        if (!zero_q) begin
                            state_d = ST_RUN;
                        end
                    end else if (press && digit_ok) begin
                        time_d.min_tens = time_q.min_ones;
                        time_d.min_ones = time_q.sec_tens;
                        time_d.sec_tens = time_q.sec_ones;
                        time_d.sec_ones = tbus.Digit;
                    end
                end
                ST_RUN: begin
                    // A tick coinciding with pause is dropped on purpose.
                    if (tbus.pause) begin
                        state_d = ST_PAUSE;
                    end else if (tbus.tick && !zero_q) begin
                        time_d = dec_time;
                        if (dec_time == '0) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (tbus.start && !tbus.pause) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (press && digit_ok) begin
                        time_d          = '0;
                        time_d.sec_ones = tbus.Digit;
                        state_d         = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        zero_d = (time_d == '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            time_q  <= '0;
            zero_q  <= 1'b1;
            done_q  <= 1'b0;
            loadn_q <= 1'b1;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
            loadn_q <= loadn_d;
        end
    end

    assign tbus.min_tens = time_q.min_tens;
    assign tbus.min_ones = time_q.min_ones;
    assign tbus.sec_tens = time_q.sec_tens;
    assign tbus.sec_ones = time_q.sec_ones;
    assign tbus.running  = (state_q == ST_RUN);
    assign tbus.zero     = zero_q;
    assign tbus.done     = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed vector table plus a hand-written countdown-to-done sequence for countdown_timer.
module tb_countdown_timer;

    logic clk;
    logic rst;

    countdown_timer_if bus();

    countdown_timer #(.SEC_TENS_WRAP(5)) dut (
        .clock (clk),
        .reset (rst),
        .tbus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit         rs;
        logic [3:0] dg;
        bit         ld;
        bit         st;
        bit         pa;
        bit         cl;
        bit         tk;
        logic [15:0] t;
        bit         r;
        bit         z;
        bit         d;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic v(input bit rs, input logic [3:0] dg, input bit ld, input bit st,
                     input bit pa, input bit cl, input bit tk,
                     input logic [15:0] t, input bit r, input bit d);
        vec_t x;
        x.rs = rs; x.dg = dg; x.ld = ld; x.st = st; x.pa = pa; x.cl = cl; x.tk = tk;
        x.t  = t;  x.r  = r;  x.z  = (t == 16'h0000); x.d = d;
        vecs.push_back(x);
    endtask

    // One-cycle press followed by one released cycle, both in IDLE.
    task automatic kp(input logic [3:0] dg, input logic [15:0] t);
        v(0, dg, 0, 0, 0, 0, 0, t, 0, 0);
        v(0, dg, 1, 0, 0, 0, 0, t, 0, 0);
    endtask

    task automatic drive(input bit rs, input logic [3:0] dg, input bit ld, input bit st,
                         input bit pa, input bit cl, input bit tk);
        @(negedge clk);
        rst = rs; bus.Digit = dg; bus.loadn = ld; bus.start = st;
        bus.pause = pa; bus.clear = cl; bus.tick = tk;
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] cur_time();
        return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
    endfunction

    initial begin
        int  n_ticks;
        bit  seen;

        rst = 1'b1; bus.Digit = 4'd0; bus.loadn = 1'b1; bus.start = 1'b0;
        bus.pause = 1'b0; bus.clear = 1'b0; bus.tick = 1'b0;

        // Reset, including reset overriding active controls.
        v(1, 0, 1, 0, 0, 0, 0, 16'h0000, 0, 0);
        v(1, 5, 0, 1, 0, 0, 1, 16'h0000, 0, 0);
        // Held presses 1,3,0 (3 cycles low, 2 high), each shifts once.
        for (int k = 0; k < 3; k++) v(0, 1, 0, 0, 0, 0, 0, 16'h0001, 0, 0);
        for (int k = 0; k < 2; k++) v(0, 1, 1, 0, 0, 0, 0, 16'h0001, 0, 0);
        for (int k = 0; k < 3; k++) v(0, 3, 0, 0, 0, 0, 0, 16'h0013, 0, 0);
        for (int k = 0; k < 2; k++) v(0, 3, 1, 0, 0, 0, 0, 16'h0013, 0, 0);
        for (int k = 0; k < 3; k++) v(0, 0, 0, 0, 0, 0, 0, 16'h0130, 0, 0);
        for (int k = 0; k < 2; k++) v(0, 0, 1, 0, 0, 0, 0, 16'h0130, 0, 0);
        kp(4'd12, 16'h0130);
        kp(4'd4,  16'h1304);
        kp(4'd5,  16'h3045);
        v(0, 0, 1, 0, 0, 1, 0, 16'h0000, 0, 0);
        // 0102 countdown with seconds borrow; tick in start cycle ignored.
        kp(1, 16'h0001); kp(0, 16'h0010); kp(2, 16'h0102);
        v(0, 0, 1, 1, 0, 0, 1, 16'h0102, 1, 0);
        v(0, 0, 1, 0, 0, 0, 1, 16'h0101, 1, 0);
        v(0, 0, 1, 0, 0, 0, 0, 16'h0101, 1, 0);
        v(0, 0, 1, 0, 0, 0, 1, 16'h0100, 1, 0);
        v(0, 0, 1, 0, 0, 0, 1, 16'h0059, 1, 0);
        v(0, 0, 1, 0, 0, 1, 0, 16'h0000, 0, 0);
        // 0002 down to done, then DONE behaviour.
        kp(2, 16'h0002);
        v(0, 0, 1, 1, 0, 0, 0, 16'h0002, 1, 0);
        v(0, 0, 1, 0, 0, 0, 1, 16'h0001, 1, 0);
        v(0, 0, 1, 0, 0, 0, 1, 16'h0000, 0, 1);
        v(0, 0, 1, 0, 0, 0, 0, 16'h0000, 0, 0);
        v(0, 0, 1, 0, 0, 0, 1, 16'h0000, 0, 0);
        v(0, 0, 1, 1, 0, 0, 0, 16'h0000, 0, 0);
        kp(7, 16'h0007);
        kp(8, 16'h0078);
        v(0, 0, 1, 0, 0, 1, 0, 16'h0000, 0, 0);
        // Pause/tick collision, ticks in PAUSE, resume, start+pause, clear in PAUSE.
        kp(3, 16'h0003); kp(0, 16'h0030);
        v(0, 0, 1, 1, 0, 0, 0, 16'h0030, 1, 0);
        v(0, 0, 1, 0, 1, 0, 1, 16'h0030, 0, 0);
        v(0, 0, 1, 0, 0, 0, 1, 16'h0030, 0, 0);
        v(0, 0, 1, 1, 0, 0, 0, 16'h0030, 1, 0);
        v(0, 0, 1, 0, 0, 0, 1, 16'h0029, 1, 0);
        v(0, 0, 1, 0, 1, 0, 0, 16'h0029, 0, 0);
        v(0, 0, 1, 1, 1, 0, 0, 16'h0029, 0, 0);
        v(0, 0, 1, 0, 0, 1, 0, 16'h0000, 0, 0);
        v(0, 0, 1, 1, 0, 0, 0, 16'h0000, 0, 0);
        // Seconds above 59 count digit-wise.
        kp(9, 16'h0009); kp(9, 16'h0099);
        v(0, 0, 1, 1, 0, 0, 0, 16'h0099, 1, 0);
        v(0, 0, 1, 0, 0, 0, 1, 16'h0098, 1, 0);
        v(0, 0, 1, 0, 0, 1, 0, 16'h0000, 0, 0);
        // Minutes borrow from the tens digit.
        kp(1, 16'h0001); kp(0, 16'h0010); kp(0, 16'h0100); kp(0, 16'h1000);
        v(0, 0, 1, 1, 0, 0, 0, 16'h1000, 1, 0);
        v(0, 0, 1, 0, 0, 0, 1, 16'h0959, 1, 0);
        v(0, 0, 1, 0, 0, 0, 1, 16'h0958, 1, 0);
        v(0, 0, 1, 0, 0, 1, 0, 16'h0000, 0, 0);
        // Press ignored in RUN; reset mid-RUN.
        kp(4, 16'h0004); kp(1, 16'h0041); kp(5, 16'h0415);
        v(0, 0, 1, 1, 0, 0, 0, 16'h0415, 1, 0);
        v(0, 6, 0, 0, 0, 0, 0, 16'h0415, 1, 0);
        v(0, 6, 1, 0, 0, 0, 0, 16'h0415, 1, 0);
        v(1, 0, 1, 0, 0, 0, 1, 16'h0000, 0, 0);
        v(0, 0, 1, 0, 0, 0, 0, 16'h0000, 0, 0);
        v(0, 0, 1, 1, 0, 0, 0, 16'h0000, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rs, vecs[i].dg, vecs[i].ld, vecs[i].st,
                  vecs[i].pa, vecs[i].cl, vecs[i].tk);
            n_cmp++;
            if (cur_time() !== vecs[i].t || bus.running !== vecs[i].r ||
                bus.zero !== vecs[i].z || bus.done !== vecs[i].d) begin
                n_bad++;
                $display("FAIL vec%0d: got time=%h run=%b zero=%b done=%b, expected time=%h run=%b zero=%b done=%b",
                         i, cur_time(), bus.running, bus.zero, bus.done,
                         vecs[i].t, vecs[i].r, vecs[i].z, vecs[i].d);
            end
        end

        // Free-running ticks from 0003: done must arrive after exactly 3 ticks, for one cycle.
        drive(0, 3, 0, 0, 0, 0, 0);
        drive(0, 3, 1, 0, 0, 0, 0);
        drive(0, 0, 1, 1, 0, 0, 0);
        check_val("run_after_start", int'(bus.running), 1);
        n_ticks = 0;
        seen    = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            drive(0, 0, 1, 0, 0, 0, 1);
            n_ticks++;
            if (bus.done === 1'b1) seen = 1'b1;
        end
        check_val("done_seen", int'(seen), 1);
        check_val("ticks_to_done", n_ticks, 3);
        check_val("time_at_done", int'(cur_time()), 0);
        drive(0, 0, 1, 0, 0, 0, 1);
        check_val("done_one_cycle", int'(bus.done), 0);
        check_val("zero_after_done", int'(bus.zero), 1);
        check_val("not_running_after_done", int'(bus.running), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Time-entry and countdown stage for the microwave controller, directly downstream of the keypad BCD encoder. It captures each encoded keypress (`Digit` qualified by active-low `loadn`) into a four-digit BCD MM:SS register by shifting left, counts the register down on each 1 Hz tick while cooking, and reports zero/done status to the magnetron control and display logic.

## Interface
- `SEC_TENS_WRAP`, default 5: value loaded into the seconds-tens digit when a borrow comes from the minutes.
- `clock` input 1: system clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high; overrides every other input.
- `Digit` input 4: BCD digit from the keypad encoder.
- `loadn` input 1: active-low keypress strobe from the encoder, level held low for ≥1 cycle per press.
- `start` input 1: start/resume request, level-sampled.
- `pause` input 1: door-open/stop request, level-sampled.
- `clear` input 1: cancel entry; zeroes the time.
- `tick` input 1: one-cycle 1 Hz enable.
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones` output 4 each: current BCD time.
- `running` output 1: high in RUN.
- `zero` output 1: registered; high when all four digits are 0.
- `done` output 1: one-cycle pulse when the countdown reaches 0000.

## Operation
- States: IDLE (entry), RUN, PAUSE, DONE. Reset state is IDLE.
- Reset values: all digits 0, `running`=0, `zero`=1, `done`=0, `loadn_q`=1.
- Keypress detect: `loadn_q` registers `loadn`. A press is `loadn`=0 and `loadn_q`=1. A held-low `loadn` counts as exactly one press.
- Press in IDLE with `Digit`≤9: shift left. `min_tens`←`min_ones`, `min_ones`←`sec_tens`, `sec_tens`←`sec_ones`, `sec_ones`←`Digit`. The old `min_tens` is discarded.
- Press with `Digit`>9: ignored, and no state change.
- Press in DONE: digits become 000`Digit`, state goes to IDLE.
- Presses in RUN or PAUSE: ignored.
- Priority in any cycle: reset > clear > pause > start > tick > keypress.
- `clear` (any state): digits 0, state IDLE.
- IDLE + `start`: go to RUN if `zero`=0, otherwise stay in IDLE.
- RUN + `pause`: go to PAUSE. Any `tick` in that same cycle is discarded.
- PAUSE + `start` (with `pause` low): go to RUN.
- DONE + `start`: ignored.
- RUN + `tick`: decrement MM:SS in BCD.
  - `sec_ones`>0: `sec_ones`−1.
  - Else `sec_tens`>0: `sec_ones`=9, `sec_tens`−1.
  - Else minutes are decremented the same way: `min_ones`>0 gives `min_ones`−1; else `min_ones`=9, `min_tens`−1. Then `sec_tens`=`SEC_TENS_WRAP`, `sec_ones`=9.
- Entered seconds above 59 (e.g. 0099) are legal and count down digit-wise: 0099→0098.
- If a decrement makes the time 0000: state goes to DONE and `done` pulses.
- Ticks in IDLE, PAUSE or DONE: ignored.
- Digits never underflow.

## Timing
- Keypress: digits update at the same edge that samples `loadn` low with `loadn_q` high, and are visible the next cycle.
- `start`/`pause`/`clear`: the state change takes effect at the sampling edge; `running` follows on the same edge.
- A `tick` in the cycle `start` is sampled does not decrement, because the state is still IDLE.
- `zero` is updated on the same edge as the digits.
- `done` is high for exactly the one cycle after the edge that writes 0000, coincident with the first cycle of DONE.
- `reset` mid-RUN: the next cycle shows IDLE, all digits 0, `zero`=1, and no `done` pulse.

## Test plan
- Presses 1,3,0 (`loadn` held low for 3 cycles each, gaps 2 cycles) -> digits 0130; a held press shifts only once; `Digit`=12 press -> still 0130.
- Entry 0102, `start`, 3 ticks -> 0101, 0100, 0059 (borrow loads 5/9); `running`=1 throughout.
- Entry 0002, `start`, 2 ticks -> 0001, then 0000 with `done`=1 for one cycle, state DONE, `zero`=1, `running`=0; a further tick causes no change.
- RUN at 0030: `pause` and `tick` in the same cycle -> PAUSE, time stays 0030; ticks ignored; `start` resumes and the next tick gives 0029.
- IDLE at 0000 + `start` -> stays IDLE; entry 0099 + run 1 tick -> 0098; `clear` in PAUSE -> 0000, IDLE.
- `reset` asserted mid-RUN at 0415 -> next cycle 0000, IDLE, `zero`=1, `done`=0; DONE + press 7 -> 0007, IDLE.
